// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/status controller: 2-wide in-order allocation,
// 3-port completion tracking and up to 2-wide in-order retirement.
module rob_ctrl #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_req1,
  input  logic             disp_req2,
  output logic             disp_grant1,
  output logic             disp_grant2,
  output logic [IDX_W-1:0] disp_idx1,
  output logic [IDX_W-1:0] disp_idx2,
  input  logic             cmp_valid1,
  input  logic             cmp_valid2,
  input  logic             cmp_valid3,
  input  logic [IDX_W-1:0] cmp_idx1,
  input  logic [IDX_W-1:0] cmp_idx2,
  input  logic [IDX_W-1:0] cmp_idx3,
  input  logic             ret_stall,
  output logic             ret_valid1,
  output logic             ret_valid2,
  output logic [IDX_W-1:0] ret_idx1,
  output logic [IDX_W-1:0] ret_idx2,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [IDX_W-1:0] head, tail, head_nx1, tail_nx1;
  logic [IDX_W:0]   free, n_grant, n_ret, count_nx;
  logic [DEPTH-1:0] valid, done, valid_nx, done_nx;
  logic [2:0]       cmp_v;
  logic [IDX_W-1:0] cmp_i [3];

  assign head_nx1 = head + IDX_W'(1);
  assign tail_nx1 = tail + IDX_W'(1);

  // Free space ignores same-cycle retirements; freed rows are reusable next cycle.
  assign free        = (IDX_W+1)'(DEPTH) - count;
  assign disp_grant1 = disp_req1 && !flush && (free >= (IDX_W+1)'(1));
  assign disp_grant2 = disp_req1 && disp_req2 && !flush && (free >= (IDX_W+1)'(2));
  assign disp_idx1   = tail;
  assign disp_idx2   = tail_nx1;

  assign ret_valid1 = !ret_stall && !flush && valid[head] && done[head];
  assign ret_valid2 = ret_valid1 && valid[head_nx1] && done[head_nx1];
  assign ret_idx1   = head;
  assign ret_idx2   = head_nx1;

  assign full  = (count == (IDX_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign n_grant  = (IDX_W+1)'(disp_grant1) + (IDX_W+1)'(disp_grant2);
  assign n_ret    = (IDX_W+1)'(ret_valid1) + (IDX_W+1)'(ret_valid2);
  assign count_nx = count + n_grant - n_ret;

  assign cmp_v    = {cmp_valid3, cmp_valid2, cmp_valid1};
  assign cmp_i[0] = cmp_idx1;
  assign cmp_i[1] = cmp_idx2;
  assign cmp_i[2] = cmp_idx3;

  // Completions only mark live rows; retire clears, then new grants install.
  always_comb begin
    valid_nx = valid;
    done_nx  = done;
    for (int p = 0; p < 3; p++) begin
      if (cmp_v[p] && valid[cmp_i[p]]) done_nx[cmp_i[p]] = 1'b1;
    end
    if (ret_valid1) begin
      valid_nx[head] = 1'b0;
      done_nx[head]  = 1'b0;
    end
    if (ret_valid2) begin
      valid_nx[head_nx1] = 1'b0;
      done_nx[head_nx1]  = 1'b0;
    end
    if (disp_grant1) begin
      valid_nx[tail] = 1'b1;
      done_nx[tail]  = 1'b0;
    end
    if (disp_grant2) begin
      valid_nx[tail_nx1] = 1'b1;
      done_nx[tail_nx1]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      head  <= head + IDX_W'(n_ret);
      tail  <= tail + IDX_W'(n_grant);
      count <= count_nx;
      valid <= valid_nx;
      done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1, flush = 1'b0;
  logic       disp_req1 = 1'b0, disp_req2 = 1'b0;
  logic       disp_grant1, disp_grant2;
  logic [3:0] disp_idx1, disp_idx2;
  logic       cmp_valid1 = 1'b0, cmp_valid2 = 1'b0, cmp_valid3 = 1'b0;
  logic [3:0] cmp_idx1 = '0, cmp_idx2 = '0, cmp_idx3 = '0;
  logic       ret_stall = 1'b0;
  logic       ret_valid1, ret_valid2;
  logic [3:0] ret_idx1, ret_idx2;
  logic [4:0] count;
  logic       full, empty;

  int checks = 0;
  int errors = 0;

  rob_ctrl #(.DEPTH(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_req1(disp_req1), .disp_req2(disp_req2),
    .disp_grant1(disp_grant1), .disp_grant2(disp_grant2),
    .disp_idx1(disp_idx1), .disp_idx2(disp_idx2),
    .cmp_valid1(cmp_valid1), .cmp_valid2(cmp_valid2), .cmp_valid3(cmp_valid3),
    .cmp_idx1(cmp_idx1), .cmp_idx2(cmp_idx2), .cmp_idx3(cmp_idx3),
    .ret_stall(ret_stall),
    .ret_valid1(ret_valid1), .ret_valid2(ret_valid2),
    .ret_idx1(ret_idx1), .ret_idx2(ret_idx2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ROB as an ordered list of live indices plus a done flag per row.
  int q[$];
  int mhead = 0;
  bit mdone[16];

  function automatic bit live(input int idx);
    foreach (q[i]) if (q[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    int sz, tl;
    bit eg1, eg2, er1, er2, c1, c2, c3;
    if (reset) begin
      q.delete();
      mhead = 0;
      foreach (mdone[i]) mdone[i] = 1'b0;
    end else begin
      sz  = q.size();
      tl  = (mhead + sz) % 16;
      eg1 = disp_req1 && !flush && (16 - sz) >= 1;
      eg2 = disp_req1 && disp_req2 && !flush && (16 - sz) >= 2;
      er1 = !ret_stall && !flush && sz > 0 && mdone[q[0]];
      er2 = er1 && sz > 1 && mdone[q[1]];
      chk("grant1", disp_grant1, eg1);
      chk("grant2", disp_grant2, eg2);
      chk("disp_idx1", disp_idx1, tl);
      chk("disp_idx2", disp_idx2, (tl + 1) % 16);
      chk("ret_valid1", ret_valid1, er1);
      chk("ret_valid2", ret_valid2, er2);
      chk("ret_idx1", ret_idx1, mhead);
      chk("ret_idx2", ret_idx2, (mhead + 1) % 16);
      chk("count", count, sz);
      chk("full", full, sz == 16);
      chk("empty", empty, sz == 0);
      if (flush) begin
        q.delete();
        mhead = 0;
        foreach (mdone[i]) mdone[i] = 1'b0;
      end else begin
        c1 = cmp_valid1 && live(int'(cmp_idx1));
        c2 = cmp_valid2 && live(int'(cmp_idx2));
        c3 = cmp_valid3 && live(int'(cmp_idx3));
        if (c1) mdone[cmp_idx1] = 1'b1;
        if (c2) mdone[cmp_idx2] = 1'b1;
        if (c3) mdone[cmp_idx3] = 1'b1;
        if (er1) begin mdone[q[0]] = 1'b0; void'(q.pop_front()); mhead = (mhead + 1) % 16; end
        if (er2) begin mdone[q[0]] = 1'b0; void'(q.pop_front()); mhead = (mhead + 1) % 16; end
        if (eg1) begin q.push_back(tl); mdone[tl] = 1'b0; end
        if (eg2) begin q.push_back((tl + 1) % 16); mdone[(tl + 1) % 16] = 1'b0; end
      end
    end
  end

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    disp_req1 = 0; disp_req2 = 0; flush = 0; ret_stall = 0;
    cmp_valid1 = 0; cmp_valid2 = 0; cmp_valid3 = 0;
  endtask

  initial begin
    repeat (2) next;
    reset = 0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_idx2", disp_idx2, 1);
    chk("rst_ret_idx2", ret_idx2, 1);

    // Fill with 8 dual dispatches.
    for (int k = 0; k < 8; k++) begin
      next;
      disp_req1 = 1; disp_req2 = 1;
      @(negedge clk);
      chk("fill_g2", disp_grant2, 1);
      chk("fill_idx1", disp_idx1, 2 * k);
      chk("fill_idx2", disp_idx2, 2 * k + 1);
    end
    next;
    @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_count", count, 16);
    chk("full_g1", disp_grant1, 0);

    // Flush with retire-eligible state absent but live entries and a completion.
    next;
    disp_req1 = 0; disp_req2 = 0; flush = 1; cmp_valid1 = 1; cmp_idx1 = 4;
    @(negedge clk);
    chk("flush_ret", ret_valid1, 0);
    next;
    idle; cmp_valid1 = 1; cmp_idx1 = 5;
    @(negedge clk);
    chk("post_flush_count", count, 0);
    chk("post_flush_idx1", disp_idx1, 0);

    // Allocate 0..3, complete 1 then 0.
    next; idle; disp_req1 = 1; disp_req2 = 1;
    next;
    next; idle; cmp_valid1 = 1; cmp_idx1 = 1;
    @(negedge clk);
    chk("ooo_no_ret_a", ret_valid1, 0);
    next; cmp_idx1 = 0;
    @(negedge clk);
    chk("ooo_no_ret_b", ret_valid1, 0);
    next; idle;
    @(negedge clk);
    chk("ooo_ret1", ret_valid1, 1);
    chk("ooo_ret2", ret_valid2, 1);
    next;
    @(negedge clk);
    chk("ooo_count", count, 2);
    chk("ooo_head", ret_idx1, 2);
    next; cmp_valid1 = 1; cmp_idx1 = 2;
    next; idle;
    @(negedge clk);
    chk("single_ret1", ret_valid1, 1);
    chk("single_ret2", ret_valid2, 0);
    next; ret_stall = 1; cmp_valid1 = 1; cmp_idx1 = 3;
    next; cmp_valid1 = 0;
    @(negedge clk);
    chk("stall_ret", ret_valid1, 0);
    next; ret_stall = 0;
    @(negedge clk);
    chk("unstall_ret", ret_valid1, 1);
    chk("unstall_idx", ret_idx1, 3);
    next;
    @(negedge clk);
    chk("drained_empty", empty, 1);

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 4000; n++) begin
      next;
      disp_req1  = ($urandom % 4) != 0;
      disp_req2  = ($urandom % 2) != 0;
      cmp_valid1 = ($urandom % 2) != 0;
      cmp_valid2 = ($urandom % 2) != 0;
      cmp_valid3 = ($urandom % 3) == 0;
      cmp_idx1   = 4'($urandom_range(0, 15));
      cmp_idx2   = 4'($urandom_range(0, 15));
      cmp_idx3   = 4'($urandom_range(0, 15));
      ret_stall  = ($urandom % 5) == 0;
      flush      = ($urandom % 80) == 0;
      reset      = ($urandom % 200) == 0;
    end
    next;
    idle; reset = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
